// File: rtl/constraint_shift_frame_eval.sv
// Streaming frame evaluator for the "OR-reduce of a left-shifted operand" constraint.
// Optional build macro CONSTRAINT_MASK_EN adds the s_mask operand mask port.
module constraint_shift_frame_eval #(
  parameter int WIDTH   = 11,
  parameter int SHAMT_W = 4,
  parameter int CNT_W   = 16,
  parameter int FID_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef CONSTRAINT_MASK_EN
  input  logic [WIDTH-1:0]   s_mask,
`endif
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  input  logic [SHAMT_W-1:0] s_shamt,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_any,
  output logic               m_all,
  output logic [CNT_W-1:0]   m_hit_cnt,
  output logic [CNT_W-1:0]   m_total_cnt,
  output logic [FID_W-1:0]   m_frame_id
);

  // Handshakes: a beat transfers on the rising edge where valid && ready are
  // both high; a source holds its payload stable while valid && !ready, and
  // ready never depends on the same interface's valid.

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] mask_eff;
  logic             hit_in;

  // Shifting in a WIDTH-wide context truncates, so shamt >= WIDTH yields zero.
  assign shifted = s_data << s_shamt;
`ifdef CONSTRAINT_MASK_EN
  assign mask_eff = s_mask;
`else
  assign mask_eff = '1;
`endif
  assign hit_in = |(shifted & mask_eff);

  logic             v1;
  logic             hit1;
  logic             last1;
  logic [CNT_W-1:0] acc_hit;
  logic [CNT_W-1:0] acc_tot;
  logic             acc_any;
  logic             acc_all;
  logic [FID_W-1:0] fid;

  logic             adv;
  logic             accept;
  logic             close;
  logic [CNT_W-1:0] hit_sum;
  logic [CNT_W-1:0] tot_sum;
  logic             any_sum;
  logic             all_sum;

  // Stage 1 stalls only when it holds a frame's last sample and the result
  // register is still occupied by an unconsumed frame.
  assign adv     = !(v1 && last1 && m_valid && !m_ready);
  assign s_ready = rst_n && adv;
  assign accept  = s_valid && s_ready;
  assign close   = v1 && last1 && adv;

  always_comb begin
    hit_sum = acc_hit;
    tot_sum = acc_tot;
    if (hit1 && (acc_hit != '1)) hit_sum = acc_hit + CNT_W'(1);
    if (acc_tot != '1)           tot_sum = acc_tot + CNT_W'(1);
    any_sum = acc_any | hit1;
    all_sum = acc_all & hit1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      hit1        <= 1'b0;
      last1       <= 1'b0;
      acc_hit     <= '0;
      acc_tot     <= '0;
      acc_any     <= 1'b0;
      acc_all     <= 1'b1;
      fid         <= '0;
      m_valid     <= 1'b0;
      m_any       <= 1'b0;
      m_all       <= 1'b0;
      m_hit_cnt   <= '0;
      m_total_cnt <= '0;
      m_frame_id  <= '0;
    end else begin
      if (adv) begin
        v1 <= accept;
        if (accept) begin
          hit1  <= hit_in;
          last1 <= s_last;
        end
      end

      if (v1 && adv) begin
        if (last1) begin
          acc_hit <= '0;
          acc_tot <= '0;
          acc_any <= 1'b0;
          acc_all <= 1'b1;
        end else begin
          acc_hit <= hit_sum;
          acc_tot <= tot_sum;
          acc_any <= any_sum;
          acc_all <= all_sum;
        end
      end

      // A closing frame wins over a same-cycle consume so m_valid stays high.
      if (close) begin
        m_valid     <= 1'b1;
        m_any       <= any_sum;
        m_all       <= all_sum;
        m_hit_cnt   <= hit_sum;
        m_total_cnt <= tot_sum;
        m_frame_id  <= fid;
        fid         <= fid + FID_W'(1);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_constraint_shift_frame_eval.sv
// Self-checking bench: a frame-level scoreboard model plus directed vectors,
// driving a default instance and a CNT_W=2 instance from the same stimulus.
module tb_constraint_shift_frame_eval;

  localparam int WIDTH   = 11;
  localparam int SHAMT_W = 4;
  localparam int FID_W   = 8;
  localparam int MAX16   = 65535;
  localparam int MAX2    = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_valid = 1'b0;
  logic [WIDTH-1:0]   s_data = '0;
  logic [SHAMT_W-1:0] s_shamt = '0;
  logic               s_last = 1'b0;
  logic [WIDTH-1:0]   s_mask = '1;
  logic               m_ready = 1'b1;

  logic        s_ready, m_valid, m_any, m_all;
  logic [15:0] m_hit_cnt, m_total_cnt;
  logic [7:0]  m_frame_id;
  logic        sat_s_ready, sat_m_valid, sat_m_any, sat_m_all;
  logic [1:0]  sat_hit_cnt, sat_total_cnt;
  logic [7:0]  sat_frame_id;

  constraint_shift_frame_eval #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .CNT_W(16), .FID_W(FID_W)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef CONSTRAINT_MASK_EN
    .s_mask(s_mask),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_shamt(s_shamt), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_any(m_any), .m_all(m_all),
    .m_hit_cnt(m_hit_cnt), .m_total_cnt(m_total_cnt), .m_frame_id(m_frame_id)
  );

  constraint_shift_frame_eval #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .CNT_W(2), .FID_W(FID_W)) dut_sat (
    .clk(clk), .rst_n(rst_n),
`ifdef CONSTRAINT_MASK_EN
    .s_mask(s_mask),
`endif
    .s_valid(s_valid), .s_ready(sat_s_ready), .s_data(s_data), .s_shamt(s_shamt), .s_last(s_last),
    .m_valid(sat_m_valid), .m_ready(m_ready), .m_any(sat_m_any), .m_all(sat_m_all),
    .m_hit_cnt(sat_hit_cnt), .m_total_cnt(sat_total_cnt), .m_frame_id(sat_frame_id)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int hits;
    int tot;
    int fid;
    int ready_at;
  } frame_t;

  frame_t exp_q[$];
  int     p_hits = 0;
  int     p_tot  = 0;
  int     m_fid  = 0;
  int     cyc    = 0;
  bit     fresh  = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit model_hit(input int data, input int shamt, input int mask);
    longint v;
    if (shamt >= WIDTH) return 1'b0;
    v = (longint'(data) << shamt) & ((64'd1 << WIDTH) - 1);
`ifdef CONSTRAINT_MASK_EN
    v = v & longint'(mask);
`endif
    return v != 0;
  endfunction

  task automatic check_frame(input frame_t f);
    check("hit_cnt",   m_hit_cnt,     min_i(f.hits, MAX16));
    check("total_cnt", m_total_cnt,   min_i(f.tot, MAX16));
    check("any",       m_any,         f.hits > 0);
    check("all",       m_all,         f.hits == f.tot);
    check("frame_id",  m_frame_id,    f.fid);
    check("sat_hit",   sat_hit_cnt,   min_i(f.hits, MAX2));
    check("sat_total", sat_total_cnt, min_i(f.tot, MAX2));
    check("sat_any",   sat_m_any,     f.hits > 0);
    check("sat_all",   sat_m_all,     f.hits == f.tot);
    check("sat_fid",   sat_frame_id,  f.fid);
  endtask

  task automatic check_zero();
    check("rst_hit",   m_hit_cnt,    0);
    check("rst_total", m_total_cnt,  0);
    check("rst_any",   m_any,        0);
    check("rst_all",   m_all,        0);
    check("rst_fid",   m_frame_id,   0);
    check("rst_sat",   sat_hit_cnt + sat_total_cnt + sat_frame_id + sat_m_any + sat_m_all, 0);
  endtask

  // Compare on every falling edge, then apply what the next rising edge will do.
  always @(negedge clk) begin
    bit mv_exp, sr_exp;
    frame_t f;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      p_hits = 0;
      p_tot  = 0;
      m_fid  = 0;
      fresh  = 1'b1;
      check("rst_s_ready", s_ready | sat_s_ready, 0);
      check("rst_m_valid", m_valid | sat_m_valid, 0);
      check_zero();
    end else begin
      mv_exp = (exp_q.size() > 0) && (exp_q[0].ready_at <= cyc);
      sr_exp = !((exp_q.size() == 2) && !m_ready);
      check("m_valid",     m_valid,     mv_exp);
      check("sat_m_valid", sat_m_valid, mv_exp);
      check("s_ready",     s_ready,     sr_exp);
      check("sat_s_ready", sat_s_ready, sr_exp);
      if (mv_exp) begin
        check_frame(exp_q[0]);
        fresh = 1'b0;
      end else if (fresh) begin
        check_zero();
      end
      if (mv_exp && m_ready) void'(exp_q.pop_front());
      if (s_valid && sr_exp) begin
        p_tot++;
        if (model_hit(int'(s_data), int'(s_shamt), int'(s_mask))) p_hits++;
        if (s_last) begin
          f.hits = p_hits; f.tot = p_tot; f.fid = m_fid; f.ready_at = cyc + 2;
          exp_q.push_back(f);
          m_fid  = (m_fid + 1) % (1 << FID_W);
          p_hits = 0;
          p_tot  = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returning at posedge+1.
  task automatic send(input int data, input int shamt, input bit last, input int mask);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = WIDTH'(data);
    s_shamt = SHAMT_W'(shamt);
    s_last  = last;
    s_mask  = WIDTH'(mask);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = 11'h5A5;
    s_shamt = 4'hF;
    s_last  = 1'b1;
  endtask

  // Returns at the falling edge where m_valid is first seen high.
  task automatic wait_result();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (m_valid) ok = 1'b1;
    end
    if (!ok) check("result_timeout", 0, 1);
  endtask

  task automatic resync();
    @(posedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int d_tab[6];
    int h_tab[6];
    d_tab = '{11'h001, 11'h400, 11'h7FF, 11'h000, 11'h0F0, 11'h081};
    h_tab = '{0, 4, 11, 3, 7, 10};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    resync();

    // Boundary hit, 2-cycle latency
    send(11'h07F, 4, 1, 11'h7FF);
    @(negedge clk); check("lat_early_valid", m_valid, 0);
    @(negedge clk);
    check("t1_valid", m_valid, 1);
    check("t1_hit", m_hit_cnt, 1);
    check("t1_total", m_total_cnt, 1);
    check("t1_any", m_any, 1);
    check("t1_all", m_all, 1);
    check("t1_fid", m_frame_id, 0);
    resync();

    // Shifted-out operand, then shamt == WIDTH
    send(11'h780, 4, 1, 11'h7FF);
    wait_result();
    check("t2_hit", m_hit_cnt, 0);
    check("t2_any", m_any, 0);
    check("t2_all", m_all, 0);
    check("t2_total", m_total_cnt, 1);
    resync();
    send(11'h7FF, 11, 1, 11'h7FF);
    wait_result();
    check("t2b_hit", m_hit_cnt, 0);
    check("t2b_fid", m_frame_id, 2);
    resync();

    // Three-sample frame, then counters restart
    send(11'h001, 4, 0, 11'h7FF);
    send(11'h400, 4, 0, 11'h7FF);
    send(11'h010, 0, 1, 11'h7FF);
    wait_result();
    check("t3_hit", m_hit_cnt, 2);
    check("t3_total", m_total_cnt, 3);
    check("t3_any", m_any, 1);
    check("t3_all", m_all, 0);
    check("t3_fid", m_frame_id, 3);
    resync();
    send(11'h001, 0, 1, 11'h7FF);
    wait_result();
    check("t3b_total", m_total_cnt, 1);
    check("t3b_fid", m_frame_id, 4);
    resync();

    // Backpressure: result A held while frame B's last waits in stage 1
    m_ready = 1'b0;
    send(11'h001, 0, 0, 11'h7FF);
    send(11'h002, 0, 1, 11'h7FF);
    send(11'h000, 0, 0, 11'h7FF);
    send(11'h003, 1, 1, 11'h7FF);
    fork
      send(11'h001, 0, 1, 11'h7FF);
      begin
        repeat (4) @(negedge clk);
        check("bp_s_ready", s_ready, 0);
        check("bp_valid", m_valid, 1);
        check("bp_hold_hit", m_hit_cnt, 2);
        check("bp_hold_fid", m_frame_id, 5);
        resync();
        m_ready = 1'b1;
        @(negedge clk); check("bp_ready_back", s_ready, 1);
        @(negedge clk);
        check("bp_b_valid", m_valid, 1);
        check("bp_b_hit", m_hit_cnt, 1);
        check("bp_b_total", m_total_cnt, 2);
        check("bp_b_all", m_all, 0);
        check("bp_b_fid", m_frame_id, 6);
        resync();
      end
    join
    repeat (4) resync();

    // Saturation on the CNT_W=2 instance
    repeat (4) send(11'h001, 0, 0, 11'h7FF);
    send(11'h001, 0, 1, 11'h7FF);
    wait_result();
    check("sat_hit3", sat_hit_cnt, 3);
    check("sat_tot3", sat_total_cnt, 3);
    check("sat_all1", sat_m_all, 1);
    check("sat_any1", sat_m_any, 1);
    check("wide_hit5", m_hit_cnt, 5);
    check("wide_fid", m_frame_id, 8);
    resync();

    // Streaming with intermittent consumer stalls
    for (int i = 0; i < 24; i++) begin
      m_ready = (i % 4) != 3;
      send(d_tab[i % 6], h_tab[(i + i / 6) % 6], (i % 3) == 2, 11'h7FF);
    end
    m_ready = 1'b1;
    repeat (8) resync();

    // Reset mid-frame with an unconsumed result outstanding
    m_ready = 1'b0;
    send(11'h001, 0, 1, 11'h7FF);
    send(11'h001, 0, 0, 11'h7FF);
    send(11'h002, 0, 0, 11'h7FF);
    rst_n = 1'b0;
    repeat (2) resync();
    rst_n = 1'b1;
    m_ready = 1'b1;
    resync();
    send(11'h0FF, 0, 1, 11'h700);
    wait_result();
    check("rst_total1", m_total_cnt, 1);
    check("rst_fid0", m_frame_id, 0);
`ifdef CONSTRAINT_MASK_EN
    check("rst_mask_hit", m_hit_cnt, 0);
    check("rst_mask_all", m_all, 0);
`else
    check("rst_nomask_hit", m_hit_cnt, 1);
    check("rst_nomask_all", m_all, 1);
`endif
    repeat (5) resync();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
